// File: rtl/fsk_transmitter_if.sv
// Word handshake between the packet framer (master) and the FSK transmitter (slave).
interface fsk_transmitter_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/fsk_transmitter.sv
// Two-tone FSK modulator: serialises words LSB-first, each bit sent as a square wave
// at FREQUENCY0 (bit 0) or FREQUENCY1 (bit 1) for one bit period.
module fsk_transmitter #(
  parameter int unsigned FREQUENCY0      = 9000,
  parameter int unsigned FREQUENCY1      = 11000,
  parameter int unsigned BAUD_RATE       = 1000,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned CLOCK_FREQUENCY = 50000000
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                enable,
  fsk_transmitter_if.slave    bus,
  output logic                fsk_out,
  output logic                busy,
  output logic                current_bit,
  output logic [31:0]         words_sent
);

  localparam logic [31:0] HALF0     = 32'(CLOCK_FREQUENCY / (2 * FREQUENCY0));
  localparam logic [31:0] HALF1     = 32'(CLOCK_FREQUENCY / (2 * FREQUENCY1));
  localparam logic [31:0] BIT_TICKS = 32'(CLOCK_FREQUENCY / BAUD_RATE);
  localparam logic [31:0] LAST_TICK = BIT_TICKS - 32'd1;
  localparam logic [31:0] LAST_BIT  = 32'(DATA_WIDTH - 1);

  if (BIT_TICKS < 2 * HALF0) begin : g_bad_bit_period
    $error("fsk_transmitter: bit period shorter than one FREQUENCY0 cycle");
  end
  if (FREQUENCY1 <= FREQUENCY0) begin : g_bad_tones
    $error("fsk_transmitter: FREQUENCY1 must exceed FREQUENCY0");
  end
  if (DATA_WIDTH < 1 || HALF1 < 1) begin : g_bad_width
    $error("fsk_transmitter: DATA_WIDTH and HALF1 must be at least 1");
  end

  typedef enum logic {IDLE, SEND} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [31:0]           bit_idx_q, bit_idx_d;
  logic [31:0]           tick_q, tick_d;
  logic [31:0]           half_q, half_d;
  logic [31:0]           words_q, words_d;
  logic                  fsk_q, fsk_d;
  logic                  busy_q, busy_d;
  logic                  cur_q, cur_d;
  logic                  rdy_en_q, rdy_en_d;

  logic        last_tick, word_end, data_ready, handshake;
  logic [31:0] half_len;

  always_comb begin
    last_tick  = (tick_q == LAST_TICK);
    word_end   = (state_q == SEND) && last_tick && (bit_idx_q == LAST_BIT);
    // rdy_en_q keeps data_ready low until the first edge after clear is released
    data_ready = ((state_q == IDLE) && rdy_en_q) || word_end;
    handshake  = bus.data_valid && data_ready && enable;
    half_len   = cur_q ? HALF1 : HALF0;
  end

  assign bus.data_ready = data_ready;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    tick_d    = tick_q;
    half_d    = half_q;
    words_d   = words_q;
    fsk_d     = fsk_q;
    busy_d    = busy_q;
    cur_d     = cur_q;
    rdy_en_d  = 1'b1;

    if (enable && state_q == SEND) begin
      if (last_tick) begin
        tick_d    = '0;
        half_d    = '0;
        fsk_d     = 1'b1;
        shreg_d   = shreg_q >> 1;
        cur_d     = shreg_d[0];
        bit_idx_d = bit_idx_q + 32'd1;
        if (word_end) begin
          words_d = words_q + 32'd1;
          state_d = IDLE;
          fsk_d   = 1'b0;
          busy_d  = 1'b0;
          cur_d   = 1'b0;
        end
      end else begin
        if (half_q == half_len - 32'd1) begin
          fsk_d  = ~fsk_q;
          half_d = '0;
        end else begin
          half_d = half_q + 32'd1;
        end
        tick_d = tick_q + 32'd1;
      end
    end

    // A handshake (from IDLE or at the last tick of a word) overrides the idle return,
    // so back-to-back words chain with no gap.
    if (handshake) begin
      state_d   = SEND;
      shreg_d   = bus.data_in;
      bit_idx_d = '0;
      tick_d    = '0;
      half_d    = '0;
      fsk_d     = 1'b1;
      busy_d    = 1'b1;
      cur_d     = bus.data_in[0];
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      tick_q    <= '0;
      half_q    <= '0;
      words_q   <= '0;
      fsk_q     <= 1'b0;
      busy_q    <= 1'b0;
      cur_q     <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      tick_q    <= tick_d;
      half_q    <= half_d;
      words_q   <= words_d;
      fsk_q     <= fsk_d;
      busy_q    <= busy_d;
      cur_q     <= cur_d;
      rdy_en_q  <= rdy_en_d;
    end
  end

  assign fsk_out     = fsk_q;
  assign busy        = busy_q;
  assign current_bit = cur_q;
  assign words_sent  = words_q;

endmodule

// File: tb/tb_fsk_transmitter.sv
// Self-checking bench for fsk_transmitter: per-cycle waveform compared against a tone model.
module tb_fsk_transmitter;

  localparam int CF = 1000, F0 = 50, F1 = 100, BR = 25, DW = 4;
  localparam int HALF0 = CF / (2 * F0);
  localparam int HALF1 = CF / (2 * F1);
  localparam int BT    = CF / BR;
  localparam int WT    = BT * DW;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        enable = 1'b0;
  logic        fsk_out, busy, current_bit;
  logic [31:0] words_sent;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_words = '0;

  fsk_transmitter_if #(.DATA_WIDTH(DW)) bus ();

  fsk_transmitter #(
    .FREQUENCY0(F0),
    .FREQUENCY1(F1),
    .BAUD_RATE(BR),
    .DATA_WIDTH(DW),
    .CLOCK_FREQUENCY(CF)
  ) dut (
    .clock(clock),
    .clear(clear),
    .enable(enable),
    .bus(bus),
    .fsk_out(fsk_out),
    .busy(busy),
    .current_bit(current_bit),
    .words_sent(words_sent)
  );

  always #5 clock = ~clock;

  // {fsk_out, busy, current_bit, data_ready} expected at cycle c (0..WT-1) of word w
  function automatic logic [3:0] model(input logic [DW-1:0] w, input int c);
    int   b, k, h;
    logic bv;
    b  = c / BT;
    k  = c % BT;
    bv = w[b];
    h  = bv ? HALF1 : HALF0;
    return {((k / h) % 2) == 0, 1'b1, bv, c == WT - 1};
  endfunction

  function automatic logic [3:0] obs();
    return {fsk_out, busy, current_bit, bus.data_ready};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [DW-1:0] w);
    bus.data_in    = w;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    bus.data_in    = DW'($urandom);
  endtask

  task automatic test_reset();
    clear = 1'b0; enable = 1'b1;
    bus.data_valid = 1'b1; bus.data_in = 4'hA;
    repeat (3) tick();
    n_checks++;
    if (obs() !== 4'b0000) begin n_fail++; $display("FAIL reset_outputs: got %b expected 0000", obs()); end
    n_checks++;
    if (words_sent !== 32'd0) begin n_fail++; $display("FAIL reset_words: got %0d expected 0", words_sent); end
    bus.data_valid = 1'b0;
    clear = 1'b1;
    #1;
    n_checks++;
    if (bus.data_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b expected 0", bus.data_ready); end
    tick();
    n_checks++;
    if (obs() !== 4'b0001) begin n_fail++; $display("FAIL idle_after_release: got %b expected 0001", obs()); end
  endtask

  task automatic test_single_word();
    logic [DW-1:0] w;
    int busy_cnt;
    w = 4'b0101; busy_cnt = 0;
    launch(w);
    for (int c = 0; c < WT; c++) begin
      n_checks++;
      if (obs() !== model(w, c)) begin n_fail++; $display("FAIL single c=%0d: got %b expected %b", c, obs(), model(w, c)); end
      busy_cnt += int'(busy);
      tick();
    end
    exp_words = exp_words + 32'd1;
    n_checks++;
    if (busy_cnt !== WT) begin n_fail++; $display("FAIL single_busy_cycles: got %0d expected %0d", busy_cnt, WT); end
    n_checks++;
    if (obs() !== 4'b0001) begin n_fail++; $display("FAIL single_idle: got %b expected 0001", obs()); end
    n_checks++;
    if (words_sent !== exp_words) begin n_fail++; $display("FAIL single_words: got %0d expected %0d", words_sent, exp_words); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w;
    int busy_cnt;
    busy_cnt = 0;
    bus.data_in = 4'hF; bus.data_valid = 1'b1;
    tick();
    bus.data_in = 4'h0;
    for (int c = 0; c < 2 * WT; c++) begin
      w = (c < WT) ? 4'hF : 4'h0;
      n_checks++;
      if (obs() !== model(w, c % WT)) begin n_fail++; $display("FAIL b2b c=%0d: got %b expected %b", c, obs(), model(w, c % WT)); end
      busy_cnt += int'(busy);
      if (c == WT) begin
        n_checks++;
        if (words_sent !== exp_words + 32'd1) begin n_fail++; $display("FAIL b2b_mid_words: got %0d expected %0d", words_sent, exp_words + 32'd1); end
      end
      if (c == 2 * WT - 1) bus.data_valid = 1'b0;
      tick();
    end
    exp_words = exp_words + 32'd2;
    n_checks++;
    if (busy_cnt !== 2 * WT) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected %0d", busy_cnt, 2 * WT); end
    n_checks++;
    if (obs() !== 4'b0001 || words_sent !== exp_words) begin
      n_fail++; $display("FAIL b2b_end: got %b/%0d expected 0001/%0d", obs(), words_sent, exp_words);
    end
  endtask

  task automatic test_freeze();
    logic [DW-1:0] w;
    int busy_cnt;
    w = 4'h3; busy_cnt = 0;
    launch(w);
    for (int c = 0; c < WT; c++) begin
      n_checks++;
      if (obs() !== model(w, c)) begin n_fail++; $display("FAIL freeze c=%0d: got %b expected %b", c, obs(), model(w, c)); end
      busy_cnt += int'(busy);
      if (c == 95) begin
        enable = 1'b0;
        repeat (17) begin
          tick();
          n_checks++;
          if (obs() !== model(w, c)) begin n_fail++; $display("FAIL frozen: got %b expected %b", obs(), model(w, c)); end
          busy_cnt += int'(busy);
        end
        enable = 1'b1;
      end
      tick();
    end
    exp_words = exp_words + 32'd1;
    n_checks++;
    if (busy_cnt !== WT + 17) begin n_fail++; $display("FAIL freeze_busy_cycles: got %0d expected %0d", busy_cnt, WT + 17); end
    n_checks++;
    if (words_sent !== exp_words) begin n_fail++; $display("FAIL freeze_words: got %0d expected %0d", words_sent, exp_words); end
  endtask

  task automatic test_clear_mid_word();
    logic [DW-1:0] w;
    w = DW'($urandom);
    launch(w);
    for (int c = 0; c <= 70; c++) begin
      n_checks++;
      if (obs() !== model(w, c)) begin n_fail++; $display("FAIL clr_pre c=%0d: got %b expected %b", c, obs(), model(w, c)); end
      if (c < 70) tick();
    end
    #2 clear = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 4'b0000) begin n_fail++; $display("FAIL clr_async: got %b expected 0000", obs()); end
    n_checks++;
    if (words_sent !== 32'd0) begin n_fail++; $display("FAIL clr_words: got %0d expected 0", words_sent); end
    exp_words = '0;
    repeat (2) tick();
    clear = 1'b1;
    tick();
    n_checks++;
    if (obs() !== 4'b0001) begin n_fail++; $display("FAIL clr_release: got %b expected 0001", obs()); end
    w = DW'($urandom);
    launch(w);
    for (int c = 0; c < WT; c++) begin
      n_checks++;
      if (obs() !== model(w, c)) begin n_fail++; $display("FAIL clr_post c=%0d: got %b expected %b", c, obs(), model(w, c)); end
      tick();
    end
    exp_words = exp_words + 32'd1;
    n_checks++;
    if (words_sent !== exp_words) begin n_fail++; $display("FAIL clr_post_words: got %0d expected %0d", words_sent, exp_words); end
  endtask

  task automatic test_valid_during_send();
    logic [DW-1:0] w;
    w = DW'($urandom);
    launch(w);
    for (int c = 0; c < WT; c++) begin
      n_checks++;
      if (obs() !== model(w, c)) begin n_fail++; $display("FAIL vds c=%0d: got %b expected %b", c, obs(), model(w, c)); end
      if (c == 50) begin bus.data_valid = 1'b1; bus.data_in = ~w; end
      if (c == 51) bus.data_valid = 1'b0;
      tick();
    end
    exp_words = exp_words + 32'd1;
    n_checks++;
    if (obs() !== 4'b0001 || words_sent !== exp_words) begin
      n_fail++; $display("FAIL vds_end: got %b/%0d expected 0001/%0d", obs(), words_sent, exp_words);
    end
  endtask

  task automatic test_random_words();
    logic [DW-1:0] w;
    int gap;
    for (int n = 0; n < 4; n++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        tick();
        n_checks++;
        if (obs() !== 4'b0001) begin n_fail++; $display("FAIL rnd_gap: got %b expected 0001", obs()); end
      end
      w = DW'($urandom);
      launch(w);
      for (int c = 0; c < WT; c++) begin
        n_checks++;
        if (obs() !== model(w, c)) begin n_fail++; $display("FAIL rnd w=%h c=%0d: got %b expected %b", w, c, obs(), model(w, c)); end
        tick();
      end
      exp_words = exp_words + 32'd1;
      n_checks++;
      if (words_sent !== exp_words) begin n_fail++; $display("FAIL rnd_words: got %0d expected %0d", words_sent, exp_words); end
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] w;
    @(negedge clock);
    force dut.words_q = 32'hFFFF_FFFF;
    tick();
    release dut.words_q;
    exp_words = 32'hFFFF_FFFF;
    tick();
    n_checks++;
    if (words_sent !== exp_words) begin n_fail++; $display("FAIL wrap_preload: got %h expected %h", words_sent, exp_words); end
    w = DW'($urandom);
    launch(w);
    repeat (WT) tick();
    exp_words = exp_words + 32'd1;
    n_checks++;
    if (words_sent !== exp_words) begin n_fail++; $display("FAIL wrap: got %h expected %h", words_sent, exp_words); end
  endtask

  initial begin
    bus.data_in = '0;
    bus.data_valid = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_freeze();
    test_clear_mid_word();
    test_valid_during_send();
    test_random_words();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
